gcd_sched: RTL and testbench

Round-robin scheduler that shares one binary-GCD engine among `NREQ` requesters in the Pollard p-1 datapath. It accepts (a, b) operand pairs over per-requester valid/ready handshakes and sequences the engine through clear, load and run phases. It returns each result, tagged with the requester index, on a single response port. Zero operands are resolved locally because the engine never completes on them.

---
 rtl/gcd_sched.sv | 168 ++++++++++++++++
 tb/tb_gcd_sched.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin front end sharing one binary-GCD engine among NREQ requesters.
// Build option GCD_SCHED_TIMEOUT_EN adds a RUN-state watchdog that reports through rsp_err.
module gcd_sched #(
    parameter int NREQ           = 4,
    parameter int W              = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    eng_reset,
    output logic [W-1:0]            eng_a,
    output logic [W-1:0]            eng_b,
    input  logic                    eng_done,
    input  logic [W-1:0]            eng_gcd,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_gcd,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_err
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic            clr_cnt;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic [NREQ-1:0] grant_oh;
    logic [W-1:0]    grant_a;
    logic [W-1:0]    grant_b;
    logic            timeout_hit;

    // Two passes give "first valid at or after rr_ptr, wrapping" without modulo arithmetic.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && req_valid[j] && (ID_W'(j) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
        grant_oh = '0;
        grant_a  = '0;
        grant_b  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (ID_W'(j) == grant_idx) begin
                grant_oh[j] = grant_found;
                grant_a     = req_a[j*W +: W];
                grant_b     = req_b[j*W +: W];
            end
        end
    end

    assign next_ptr  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign req_ready = (state == IDLE && reset) ? grant_oh : '0;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    // Counter is zeroed while in CLR, so it always starts from 0 on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == CLR) begin
                tmo_cnt <= '0;
            end else if (state == RUN && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (state == IDLE && grant_found) begin
                rsp_err <= 1'b0;
            end else if (state == RUN && !eng_done && timeout_hit) begin
                rsp_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign rsp_err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            clr_cnt   <= 1'b0;
            eng_reset <= 1'b1;
            eng_a     <= '0;
            eng_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_gcd   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr <= next_ptr;
                        rsp_id <= grant_idx;
                        eng_a  <= grant_a;
                        eng_b  <= grant_b;
                        // The engine never finishes on a zero operand, so answer it here.
                        if (grant_a == '0 || grant_b == '0) begin
                            rsp_gcd   <= (grant_a == '0) ? grant_b : grant_a;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            clr_cnt <= 1'b0;
                            state   <= CLR;
                        end
                    end
                end
                CLR: begin
                    if (clr_cnt) begin
                        eng_reset <= 1'b0;
                        state     <= RUN;
                    end else begin
                        clr_cnt <= 1'b1;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        rsp_gcd   <= eng_gcd;
                        rsp_valid <= 1'b1;
                        eng_reset <= 1'b1;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        rsp_gcd   <= '0;
                        rsp_valid <= 1'b1;
                        eng_reset <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: scoreboard bench for gcd_sched driving a behavioural GCD engine stub.
// Define GCD_SCHED_TIMEOUT_EN for both files to include the watchdog scenario.
module tb_gcd_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;
    localparam int TMO  = 16;

    typedef struct {
        int           id;
        logic [W-1:0] gcd;
        logic         err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              eng_reset;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_done = 1'b0;
    logic [W-1:0]      eng_gcd = '0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_gcd;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   eng_cnt  = 0;
    int   eng_lat  = 3;
    bit   eng_hang = 1'b0;
    logic exp_err  = 1'b0;

    rsp_t         sb_q[$];
    rsp_t         obs_q[$];
    int           grant_log[$];
    int           last_grant_cyc = 0;
    int           last_hs_cyc = 0;
    int           rsp_rise_cyc = 0;
    bit           prev_rsp_valid = 1'b0;
    bit           eng_reset_low_seen = 1'b0;
    int           bad_ready = 0;
    logic [W-1:0] exp_val [NREQ];
    logic [NREQ-1:0] drop_mask;

    gcd_sched #(.NREQ(NREQ), .W(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .eng_reset(eng_reset), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_gcd(eng_gcd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_gcd(rsp_gcd), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic string show(input rsp_t r);
        return $sformatf("id=%0d gcd=%0d err=%0b", r.id, r.gcd, r.err);
    endfunction

    // Engine stub: done rises eng_lat+1 cycles after eng_reset drops; result is garbage until then.
    always @(posedge clk) begin
        if (eng_reset) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
            eng_gcd  <= 32'hDEAD_BEEF;
        end else if (!eng_hang && !eng_done) begin
            if (eng_cnt >= eng_lat) begin
                eng_done <= 1'b1;
                eng_gcd  <= ref_gcd(eng_a, eng_b);
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // One clock: observe at negedge, then release granted requesters just after the posedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        drop_mask = '0;
        if (req_ready != '0) begin
            if ($countones(req_ready) != 1) bad_ready++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    if (!req_valid[i]) bad_ready++;
                    grant_log.push_back(i);
                    last_grant_cyc = cyc;
                    drop_mask[i] = 1'b1;
                    sb_q.push_back('{i, exp_val[i], exp_err});
                end
            end
        end
        if (!eng_reset) eng_reset_low_seen = 1'b1;
        if (rsp_valid && !prev_rsp_valid) rsp_rise_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
            obs_q.push_back('{int'(rsp_id), rsp_gcd, rsp_err});
            last_hs_cyc = cyc;
        end
        prev_rsp_valid = rsp_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop_mask;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        exp_val[i]      = e;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_grant(input int budget);
        int k;
        k = 0;
        while (grant_log.size() == 0 && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_rsps(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (obs_q.size() < n) begin
            n_checks++;
            $display("[TB] FAIL %s_wait: got %0d responses, expected %0d within %0d cycles",
                     tag, obs_q.size(), n, budget);
        end
    endtask

    task automatic pop_pair(output rsp_t e, output rsp_t o, output bit ok);
        ok = (sb_q.size() > 0 && obs_q.size() > 0);
        if (ok) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = '1;
        grant_log.delete();
        repeat (3) tick();
        n_checks++;
        if ({rsp_valid, eng_reset, rsp_err, req_ready} !== {1'b0, 1'b1, 1'b0, 4'b0000})
            $display("[TB] FAIL reset_ctrl: got valid=%b eng_reset=%b err=%b ready=%b, expected 0 1 0 0000",
                     rsp_valid, eng_reset, rsp_err, req_ready);
        else n_pass++;
        n_checks++;
        if ({eng_a, eng_b, rsp_gcd, rsp_id} !== '0)
            $display("[TB] FAIL reset_data: got eng_a=%0d eng_b=%0d gcd=%0d id=%0d, expected all 0",
                     eng_a, eng_b, rsp_gcd, rsp_id);
        else n_pass++;
        n_checks++;
        if (grant_log.size() != 0)
            $display("[TB] FAIL reset_no_grant: got %0d grants during reset, expected 0", grant_log.size());
        else n_pass++;
        req_valid = '0;
        sb_q.delete();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        rsp_t e, o;
        bit   ok;
        rsp_ready = 1'b1;
        eng_lat   = 3;
        grant_log.delete();
        set_req(0, 48, 18, 6);
        wait_rsps(1, 60, "single");
        n_checks++;
        if (grant_log.size() != 1 || grant_log[0] != 0)
            $display("[TB] FAIL single_grant: got %0d grants (first %0d), expected one grant to 0",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        else n_pass++;
        // Grant cycle, 2 CLR cycles, eng_lat+2 RUN cycles, then RESP.
        n_checks++;
        if (rsp_rise_cyc - last_grant_cyc != 5 + eng_lat)
            $display("[TB] FAIL single_latency: got %0d cycles, expected %0d",
                     rsp_rise_cyc - last_grant_cyc, 5 + eng_lat);
        else n_pass++;
        pop_pair(e, o, ok);
        n_checks++;
        if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
            $display("[TB] FAIL single_rsp: got %s, expected %s", ok ? show(o) : "none", show(e));
        else n_pass++;
    endtask

    task automatic test_round_robin();
        rsp_t e, o;
        bit   ok;
        int   exp_order [5];
        int   got;
        exp_order = '{0, 1, 2, 3, 0};
        apply_reset();
        grant_log.delete();
        set_req(0, 12, 8, 4);
        set_req(1, 9, 6, 3);
        set_req(2, 35, 21, 7);
        set_req(3, 64, 48, 16);
        wait_grant(10);
        set_req(0, 100, 75, 25);
        wait_rsps(5, 200, "rr");
        for (int g = 0; g < 5; g++) begin
            got = (g < grant_log.size()) ? grant_log[g] : -1;
            n_checks++;
            if (got != exp_order[g])
                $display("[TB] FAIL rr_grant%0d: got requester %0d, expected %0d", g, got, exp_order[g]);
            else n_pass++;
        end
        for (int r = 0; r < 5; r++) begin
            pop_pair(e, o, ok);
            n_checks++;
            if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
                $display("[TB] FAIL rr_rsp%0d: got %s, expected %s", r, ok ? show(o) : "none",
                         ok ? show(e) : "none");
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        rsp_t e, o;
        bit   ok;
        logic [W-1:0] ops [3][2];
        ops = '{'{32'd0, 32'd77}, '{32'd0, 32'd0}, '{32'd91, 32'd0}};
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            eng_reset_low_seen = 1'b0;
            set_req(2, ops[t][0], ops[t][1], ops[t][0] | ops[t][1]);
            wait_rsps(1, 20, "bypass");
            n_checks++;
            if (rsp_rise_cyc - last_grant_cyc != 1 || eng_reset_low_seen)
                $display("[TB] FAIL bypass%0d_timing: got latency %0d eng_reset_dropped=%b, expected 1 and 0",
                         t, rsp_rise_cyc - last_grant_cyc, eng_reset_low_seen);
            else n_pass++;
            pop_pair(e, o, ok);
            n_checks++;
            if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
                $display("[TB] FAIL bypass%0d_rsp: got %s, expected %s", t, ok ? show(o) : "none",
                         ok ? show(e) : "none");
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        rsp_t e, o;
        bit   ok;
        int   k, g0, changes, hs1;
        logic [W+IDW:0] snap;
        rsp_ready = 1'b0;
        grant_log.delete();
        set_req(1, 60, 45, 15);
        wait_grant(10);
        set_req(3, 14, 21, 7);
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (!rsp_valid) $display("[TB] FAIL bp_rsp_valid: got 0, expected 1 within 40 cycles");
        else n_pass++;
        snap    = {rsp_gcd, rsp_id, rsp_err};
        g0      = grant_log.size();
        changes = 0;
        repeat (10) begin
            tick();
            if (!rsp_valid || {rsp_gcd, rsp_id, rsp_err} !== snap) changes++;
        end
        n_checks++;
        if (changes != 0) $display("[TB] FAIL bp_stable: got %0d unstable cycles, expected 0", changes);
        else n_pass++;
        n_checks++;
        if (grant_log.size() != g0)
            $display("[TB] FAIL bp_no_grant: got %0d grants while stalled, expected 0", grant_log.size() - g0);
        else n_pass++;
        rsp_ready = 1'b1;
        k = 0;
        while (obs_q.size() == 0 && k < 5) begin
            tick();
            k++;
        end
        hs1 = last_hs_cyc;
        wait_rsps(2, 60, "bp");
        n_checks++;
        if (last_grant_cyc != hs1 + 1)
            $display("[TB] FAIL bp_next_grant: got grant %0d cycles after handshake, expected 1",
                     last_grant_cyc - hs1);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            pop_pair(e, o, ok);
            n_checks++;
            if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
                $display("[TB] FAIL bp_rsp%0d: got %s, expected %s", r, ok ? show(o) : "none",
                         ok ? show(e) : "none");
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        rsp_t e, o;
        bit   ok;
        rsp_ready = 1'b1;
        eng_hang  = 1'b1;
        grant_log.delete();
        set_req(1, 30, 20, 10);
        wait_grant(10);
        repeat (3) tick();
        n_checks++;
        if (eng_reset !== 1'b0) $display("[TB] FAIL mid_run_reached: got eng_reset=%b, expected 0", eng_reset);
        else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (rsp_valid !== 1'b0 || eng_reset !== 1'b1 || obs_q.size() != 0)
            $display("[TB] FAIL mid_run_reset: got valid=%b eng_reset=%b responses=%0d, expected 0 1 0",
                     rsp_valid, eng_reset, obs_q.size());
        else n_pass++;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        eng_hang = 1'b0;
        grant_log.delete();
        set_req(2, 27, 18, 9);
        set_req(0, 40, 24, 8);
        wait_rsps(2, 60, "mid_run");
        n_checks++;
        if (grant_log.size() < 2 || grant_log[0] != 0 || grant_log[1] != 2)
            $display("[TB] FAIL mid_run_ptr: got first grant %0d, expected 0 then 2",
                     (grant_log.size() > 0) ? grant_log[0] : -1);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            pop_pair(e, o, ok);
            n_checks++;
            if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
                $display("[TB] FAIL mid_run_rsp%0d: got %s, expected %s", r, ok ? show(o) : "none",
                         ok ? show(e) : "none");
            else n_pass++;
        end
    endtask

    task automatic test_random();
        rsp_t e, o;
        bit   ok;
        logic [W-1:0] a, b, f;
        rsp_ready = 1'b1;
        for (int round = 0; round < 4; round++) begin
            eng_lat = int'($urandom_range(0, 6));
            for (int i = 0; i < NREQ; i++) begin
                f = W'($urandom_range(1, 50));
                a = ($urandom_range(0, 7) == 0) ? '0 : f * W'($urandom_range(1, 400));
                b = ($urandom_range(0, 7) == 0) ? '0 : f * W'($urandom_range(1, 400));
                set_req(i, a, b, ref_gcd(a, b));
            end
            wait_rsps(NREQ, 200, "random");
            for (int r = 0; r < NREQ; r++) begin
                pop_pair(e, o, ok);
                n_checks++;
                if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
                    $display("[TB] FAIL random%0d_rsp%0d: got %s, expected %s", round, r,
                             ok ? show(o) : "none", ok ? show(e) : "none");
                else n_pass++;
            end
        end
        n_checks++;
        if (bad_ready != 0)
            $display("[TB] FAIL ready_onehot: got %0d bad req_ready cycles, expected 0", bad_ready);
        else n_pass++;
    endtask

`ifdef GCD_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        rsp_t e, o;
        bit   ok;
        rsp_ready = 1'b1;
        eng_hang  = 1'b1;
        exp_err   = 1'b1;
        set_req(2, 10, 4, 0);
        wait_rsps(1, 60, "timeout");
        eng_hang = 1'b0;
        exp_err  = 1'b0;
        // Three cycles to reach RUN, then TMO+1 cycles of watchdog.
        n_checks++;
        if (rsp_rise_cyc - last_grant_cyc != 3 + TMO + 1)
            $display("[TB] FAIL timeout_latency: got %0d cycles, expected %0d",
                     rsp_rise_cyc - last_grant_cyc, 3 + TMO + 1);
        else n_pass++;
        pop_pair(e, o, ok);
        n_checks++;
        if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
            $display("[TB] FAIL timeout_rsp: got %s, expected %s", ok ? show(o) : "none", show(e));
        else n_pass++;
        set_req(3, 10, 4, 2);
        wait_rsps(1, 60, "after_timeout");
        pop_pair(e, o, ok);
        n_checks++;
        if (!ok || o.id != e.id || o.gcd !== e.gcd || o.err !== e.err)
            $display("[TB] FAIL after_timeout_rsp: got %s, expected %s", ok ? show(o) : "none", show(e));
        else n_pass++;
    endtask
`endif

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) exp_val[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_bypass();
        test_backpressure();
        test_reset_mid_run();
        test_random();
`ifdef GCD_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
